tx_resp_arbiter: RTL and testbench

- Shares the single UART TX FIFO write port between two response producers: register-file read data (1 byte) and ALU results (2 bytes, LSB first).
- Each producer gets a one-entry holding buffer.
- A round-robin FSM serialises buffered responses into FIFO pushes under FIFO-full backpressure.
- Sits between the system controller's response paths and the TX async FIFO write side, in the reference clock domain.

---
 rtl/tx_resp_arbiter_if.sv | 33 +++
 rtl/tx_resp_arbiter.sv | 120 ++++++++++++
 tb/tb_tx_resp_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_resp_arbiter_if.sv
// tx_resp_arbiter_if
//   Bundles the two response producers, the TX FIFO write side and the
//   status flags of the response arbiter.
//   Producer side : RD_DATA/RD_VLD (register read byte), ALU_RES/ALU_VLD
//                   (two-byte ALU result), OVF_CLR.
//   FIFO side     : FIFO_FULL in, WR_DATA/WR_INC out.
//   Status        : RD_BUSY, ALU_BUSY, OVF.
//   Modports: master = producers/FIFO environment, slave = arbiter.
interface tx_resp_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   RD_DATA;
  logic                    RD_VLD;
  logic [2*DATA_WIDTH-1:0] ALU_RES;
  logic                    ALU_VLD;
  logic                    FIFO_FULL;
  logic                    OVF_CLR;
  logic [DATA_WIDTH-1:0]   WR_DATA;
  logic                    WR_INC;
  logic                    RD_BUSY;
  logic                    ALU_BUSY;
  logic                    OVF;

  modport master (
    output RD_DATA, RD_VLD, ALU_RES, ALU_VLD, FIFO_FULL, OVF_CLR,
    input  WR_DATA, WR_INC, RD_BUSY, ALU_BUSY, OVF
  );

  modport slave (
    input  RD_DATA, RD_VLD, ALU_RES, ALU_VLD, FIFO_FULL, OVF_CLR,
    output WR_DATA, WR_INC, RD_BUSY, ALU_BUSY, OVF
  );
endinterface

// File: rtl/tx_resp_arbiter.sv
// tx_resp_arbiter
//   Shares the single TX FIFO write port between register read responses
//   (one byte) and ALU results (two bytes, LSB first). Each producer has a
//   one-entry holding buffer; a round-robin FSM turns buffered responses
//   into FIFO pushes, holding while the FIFO is full.
//   Ports:
//     CLK  - reference clock
//     RST  - asynchronous active-low reset
//     bus  - tx_resp_arbiter_if.slave (producers, FIFO write side, flags)
module tx_resp_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  tx_resp_arbiter_if.slave   bus
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] SEND_RD     = 2'd1;
  localparam logic [1:0] SEND_ALU_LO = 2'd2;
  localparam logic [1:0] SEND_ALU_HI = 2'd3;

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic                    last_alu;      // 1: ALU was granted most recently
  logic                    last_alu_nxt;
  logic                    rd_busy;
  logic [DATA_WIDTH-1:0]   rd_buf;
  logic                    alu_busy;
  logic [2*DATA_WIDTH-1:0] alu_buf;
  logic                    ovf;

  logic                    wr_inc;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_release;
  logic                    alu_release;
  logic                    rd_take;
  logic                    alu_take;
  logic                    ovf_set;

  // Push side: purely from registered state and buffers.
  always_comb begin
    wr_inc  = (state != IDLE) && !bus.FIFO_FULL;
    wr_data = '0;
    case (state)
      SEND_RD:     wr_data = rd_buf;
      SEND_ALU_LO: wr_data = alu_buf[DATA_WIDTH-1:0];
      SEND_ALU_HI: wr_data = alu_buf[2*DATA_WIDTH-1:DATA_WIDTH];
      default:     wr_data = '0;
    endcase
  end

  // A buffer whose final byte goes out this cycle may accept a new strobe.
  assign rd_release  = (state == SEND_RD)     && wr_inc;
  assign alu_release = (state == SEND_ALU_HI) && wr_inc;
  assign rd_take     = bus.RD_VLD  && (!rd_busy  || rd_release);
  assign alu_take    = bus.ALU_VLD && (!alu_busy || alu_release);
  assign ovf_set     = (bus.RD_VLD && !rd_take) || (bus.ALU_VLD && !alu_take);

  // Arbitration happens only in IDLE; a started ALU frame runs to completion.
  always_comb begin
    state_nxt    = state;
    last_alu_nxt = last_alu;
    case (state)
      IDLE: begin
        if (rd_busy && (!alu_busy || last_alu)) begin
          state_nxt    = SEND_RD;
          last_alu_nxt = 1'b0;
        end else if (alu_busy) begin
          state_nxt    = SEND_ALU_LO;
          last_alu_nxt = 1'b1;
        end
      end
      SEND_RD:     if (wr_inc) state_nxt = IDLE;
      SEND_ALU_LO: if (wr_inc) state_nxt = SEND_ALU_HI;
      SEND_ALU_HI: if (wr_inc) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      last_alu <= 1'b1;
      rd_busy  <= 1'b0;
      rd_buf   <= '0;
      alu_busy <= 1'b0;
      alu_buf  <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_alu <= last_alu_nxt;

      if (rd_take) begin
        rd_buf  <= bus.RD_DATA;
        rd_busy <= 1'b1;
      end else if (rd_release) begin
        rd_busy <= 1'b0;
      end

      if (alu_take) begin
        alu_buf  <= bus.ALU_RES;
        alu_busy <= 1'b1;
      end else if (alu_release) begin
        alu_busy <= 1'b0;
      end

      // A new overflow outranks a coincident clear.
      if (ovf_set)          ovf <= 1'b1;
      else if (bus.OVF_CLR) ovf <= 1'b0;
    end
  end

  assign bus.WR_INC   = wr_inc;
  assign bus.WR_DATA  = wr_data;
  assign bus.RD_BUSY  = rd_busy;
  assign bus.ALU_BUSY = alu_busy;
  assign bus.OVF      = ovf;

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// tb_tx_resp_arbiter
//   Directed scenarios followed by random traffic. The driver advances a
//   transaction-level reference model each cycle and queues expected pushes;
//   a monitor process compares every FIFO push and the status flags.
module tb_tx_resp_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_resp_arbiter_if #(.DATA_WIDTH(8)) bus();

  tx_resp_arbiter #(.DATA_WIDTH(8)) u_dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: holding buffers as queues of at most one entry,
  // the frame in flight as a queue of remaining bytes.
  logic [7:0]  rd_q[$];
  logic [15:0] alu_q[$];
  logic [7:0]  frame_q[$];
  int          frame_src = 0;   // 0 none, 1 register read, 2 ALU
  bit          m_last_alu = 1'b1;
  bit          m_ovf = 1'b0;

  // Expected values for the current cycle, read by the monitor.
  bit          exp_rd_busy = 1'b0;
  bit          exp_alu_busy = 1'b0;
  bit          exp_ovf = 1'b0;
  bit          exp_push_now = 1'b0;
  int          exp_cyc[$];
  logic [7:0]  exp_dat[$];

  task automatic model_reset();
    rd_q.delete();
    alu_q.delete();
    frame_q.delete();
    exp_cyc.delete();
    exp_dat.delete();
    frame_src    = 0;
    m_last_alu   = 1'b1;
    m_ovf        = 1'b0;
    exp_rd_busy  = 1'b0;
    exp_alu_busy = 1'b0;
    exp_ovf      = 1'b0;
    exp_push_now = 1'b0;
  endtask

  task automatic model_step(input bit rdv, input logic [7:0] rdd,
                            input bit aluv, input logic [15:0] alud,
                            input bit full, input bit clr);
    bit idle0, rdocc, aluocc, oset;
    idle0  = (frame_src == 0);
    rdocc  = (rd_q.size() != 0);
    aluocc = (alu_q.size() != 0);
    exp_rd_busy  = rdocc;
    exp_alu_busy = aluocc;
    exp_ovf      = m_ovf;
    exp_push_now = 1'b0;
    // One byte of the frame in flight leaves whenever the FIFO has room.
    if (frame_src != 0 && !full) begin
      exp_cyc.push_back(cyc);
      exp_dat.push_back(frame_q.pop_front());
      exp_push_now = 1'b1;
      if (frame_q.size() == 0) begin
        if (frame_src == 1) rd_q.delete();
        else                alu_q.delete();
        frame_src = 0;
      end
    end
    // Grant from idle, round robin on ties.
    if (idle0) begin
      if (rdocc && (!aluocc || m_last_alu)) begin
        frame_src  = 1;
        frame_q.push_back(rd_q[0]);
        m_last_alu = 1'b0;
      end else if (aluocc) begin
        frame_src  = 2;
        frame_q.push_back(alu_q[0][7:0]);
        frame_q.push_back(alu_q[0][15:8]);
        m_last_alu = 1'b1;
      end
    end
    // Strobes land in a free (or just-freed) buffer, otherwise overflow.
    oset = 1'b0;
    if (rdv) begin
      if (rd_q.size() == 0) rd_q.push_back(rdd);
      else                  oset = 1'b1;
    end
    if (aluv) begin
      if (alu_q.size() == 0) alu_q.push_back(alud);
      else                   oset = 1'b1;
    end
    if (oset)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic cycle(input bit rdv, input logic [7:0] rdd,
                       input bit aluv, input logic [15:0] alud,
                       input bit full, input bit clr);
    @(negedge clk);
    cyc++;
    rst_n         = 1'b1;
    bus.RD_VLD    = rdv;
    bus.RD_DATA   = rdd;
    bus.ALU_VLD   = aluv;
    bus.ALU_RES   = alud;
    bus.FIFO_FULL = full;
    bus.OVF_CLR   = clr;
    model_step(rdv, rdd, aluv, alud, full, clr);
  endtask

  task automatic idle(input int n, input bit full);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 16'h0000, full, 0);
  endtask

  // Reset asserted half a cycle away from the clock edge; outputs must clear
  // without waiting for a rising edge.
  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rst_n         = 1'b0;
    bus.RD_VLD    = 1'b0;
    bus.RD_DATA   = 8'h00;
    bus.ALU_VLD   = 1'b0;
    bus.ALU_RES   = 16'h0000;
    bus.FIFO_FULL = 1'b0;
    bus.OVF_CLR   = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.WR_INC, bus.WR_DATA, bus.RD_BUSY, bus.ALU_BUSY, bus.OVF} != 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got inc=%0b data=%02h rdb=%0b alub=%0b ovf=%0b, want all 0",
               bus.WR_INC, bus.WR_DATA, bus.RD_BUSY, bus.ALU_BUSY, bus.OVF);
    end
  endtask

  // Monitor: samples between edges, pops the scoreboard on every push.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (exp_cyc.size() != 0 && exp_cyc[0] < cyc) begin
        void'(exp_cyc.pop_front());
        void'(exp_dat.pop_front());
      end
      checks++;
      if (bus.WR_INC !== exp_push_now) begin
        errors++;
        $display("FAIL push_strobe cyc %0d: got WR_INC=%0b, want %0b", cyc, bus.WR_INC, exp_push_now);
      end
      if (bus.WR_INC === 1'b1) begin
        checks++;
        if (exp_dat.size() == 0) begin
          errors++;
          $display("FAIL push_data cyc %0d: got %02h, want no push", cyc, bus.WR_DATA);
        end else begin
          if (exp_cyc[0] != cyc || bus.WR_DATA !== exp_dat[0]) begin
            errors++;
            $display("FAIL push_data cyc %0d: got %02h, want %02h (expected cyc %0d)",
                     cyc, bus.WR_DATA, exp_dat[0], exp_cyc[0]);
          end
          void'(exp_cyc.pop_front());
          void'(exp_dat.pop_front());
        end
      end
      checks++;
      if (bus.RD_BUSY !== exp_rd_busy || bus.ALU_BUSY !== exp_alu_busy || bus.OVF !== exp_ovf) begin
        errors++;
        $display("FAIL flags cyc %0d: got rdb=%0b alub=%0b ovf=%0b, want rdb=%0b alub=%0b ovf=%0b",
                 cyc, bus.RD_BUSY, bus.ALU_BUSY, bus.OVF, exp_rd_busy, exp_alu_busy, exp_ovf);
      end
    end
  end

  initial begin
    bus.RD_VLD    = 1'b0;
    bus.RD_DATA   = 8'h00;
    bus.ALU_VLD   = 1'b0;
    bus.ALU_RES   = 16'h0000;
    bus.FIFO_FULL = 1'b0;
    bus.OVF_CLR   = 1'b0;
    do_reset();
    do_reset();

    // Register read alone.
    cycle(1, 8'h5A, 0, 16'h0000, 0, 0);
    idle(4, 0);

    // ALU result under backpressure.
    cycle(0, 8'h00, 1, 16'h1234, 1, 0);
    idle(3, 1);
    idle(4, 0);

    // Tie straight after reset, then a second tie.
    do_reset();
    cycle(1, 8'hA1, 1, 16'hBEEF, 0, 0);
    idle(6, 0);
    cycle(1, 8'hA1, 1, 16'hBEEF, 0, 0);
    idle(6, 0);

    // Overflow, set-beats-clear, clear alone.
    cycle(1, 8'h11, 0, 16'h0000, 1, 0);
    cycle(1, 8'h22, 0, 16'h0000, 1, 0);
    cycle(1, 8'h23, 0, 16'h0000, 1, 1);
    cycle(0, 8'h00, 0, 16'h0000, 1, 1);
    idle(4, 0);

    // Capture in the same cycle the previous byte is released.
    cycle(1, 8'h22, 0, 16'h0000, 0, 0);
    idle(1, 0);
    cycle(1, 8'h33, 0, 16'h0000, 0, 0);
    idle(4, 0);

    // Reset right after the low byte of an ALU result went out.
    cycle(0, 8'h00, 1, 16'h1234, 0, 0);
    idle(2, 0);
    do_reset();
    idle(6, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) == 0, 8'($urandom),
              $urandom_range(0, 3) == 0, 16'($urandom),
              $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      end
    end
    idle(10, 0);

    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
